// File: rtl/shift_arbiter_seq.sv
// Iterative right shifter (logical / arithmetic / rotate) shared by two requesters
// through a round-robin grant, one bit per clock, with a valid/ready result port.
module shift_arbiter_seq #(
  parameter int WIDTH = 32,
  parameter int SHIFT = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_data,
  input  logic [SHIFT:0]   req0_amount,
  input  logic [3:0]       req0_mode,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_data,
  input  logic [SHIFT:0]   req1_amount,
  input  logic [3:0]       req1_mode,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_id,
  output logic             res_error,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int LW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           state, next_state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] shifted;
  logic [3:0]       mode_q;
  logic             id_q;
  logic             err_q;
  logic             ptr;

  logic             grant;
  logic             accept;
  logic [WIDTH-1:0] sel_data;
  logic [SHIFT:0]   sel_amount;
  logic [3:0]       sel_mode;
  logic             sel_illegal;
  logic [CW-1:0]    eff_count;

  // Grant and operand selection; the pointer only matters when both requesters are valid.
  always_comb begin
    grant       = (req0_valid && req1_valid) ? ptr : req1_valid;
    accept      = (state == S_IDLE) && (req0_valid || req1_valid);
    sel_data    = grant ? req1_data   : req0_data;
    sel_amount  = grant ? req1_amount : req0_amount;
    sel_mode    = grant ? req1_mode   : req0_mode;
    sel_illegal = !((sel_mode == 4'b0001) || (sel_mode == 4'b0010) || (sel_mode == 4'b1000));
    // Rotate wraps modulo WIDTH (WIDTH is a power of two); other modes saturate at WIDTH.
    if (sel_mode == 4'b1000)
      eff_count = CW'(sel_amount[LW-1:0]);
    else if (32'(sel_amount) > 32'(WIDTH))
      eff_count = CW'(WIDTH);
    else
      eff_count = CW'(sel_amount);
  end

  always_comb begin
    case (mode_q)
      4'b0010: shifted = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
      4'b1000: shifted = {data_q[0], data_q[WIDTH-1:1]};
      default: shifted = {1'b0, data_q[WIDTH-1:1]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (accept) next_state = (sel_illegal || eff_count == '0) ? S_DONE : S_SHIFT;
      S_SHIFT: if (count == CW'(1)) next_state = S_DONE;
      S_DONE:  if (res_ready) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    req0_ready = (state == S_IDLE) && req0_valid && !grant;
    req1_ready = (state == S_IDLE) && req1_valid && grant;
    res_valid  = (state == S_DONE);
    busy       = (state != S_IDLE);
    res_data   = data_q;
    res_id     = id_q;
    res_error  = err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      data_q <= '0;
      mode_q <= '0;
      id_q   <= 1'b0;
      err_q  <= 1'b0;
      ptr    <= 1'b0;
    end else if (accept) begin
      count  <= eff_count;
      data_q <= sel_data;
      mode_q <= sel_mode;
      id_q   <= grant;
      err_q  <= sel_illegal;
    end else if (state == S_SHIFT) begin
      data_q <= shifted;
      count  <= count - CW'(1);
    end else if (state == S_DONE && res_ready) begin
      ptr <= ~id_q;
    end
  end

endmodule

// File: tb/tb_shift_arbiter_seq.sv
// Self-checking bench for shift_arbiter_seq: directed table, arbitration,
// backpressure, reset-abort sequences and randomized ops against a reference model.
module tb_shift_arbiter_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_data, req1_data;
  logic [5:0]  req0_amount, req1_amount;
  logic [3:0]  req0_mode, req1_mode;
  logic        res_valid, res_ready, res_id, res_error, busy;
  logic [31:0] res_data;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int          id;
    logic [31:0] data;
    logic [5:0]  amount;
    logic [3:0]  mode;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t tbl[12];

  always #5 clk = ~clk;

  shift_arbiter_seq #(.WIDTH(32), .SHIFT(5)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req0_amount(req0_amount), .req0_mode(req0_mode),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .req1_amount(req1_amount), .req1_mode(req1_mode),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_id(res_id), .res_error(res_error), .busy(busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: shift by the effective amount in one go using native operators.
  function automatic logic [31:0] modelResult(input logic [31:0] d, input logic [5:0] a,
                                              input logic [3:0] m, output logic err,
                                              output int lat);
    int c;
    err = !(m == 4'b0001 || m == 4'b0010 || m == 4'b1000);
    if (err) begin
      lat = 0;
      return d;
    end
    c = (m == 4'b1000) ? (int'(a) % 32) : ((int'(a) > 32) ? 32 : int'(a));
    lat = c;
    if (m == 4'b0001) return (c >= 32) ? 32'h0 : (d >> c);
    if (m == 4'b0010) return (c >= 32) ? {32{d[31]}} : 32'($signed(d) >>> c);
    return (c == 0) ? d : ((d >> c) | (d << (32 - c)));
  endfunction

  task automatic waitResult(output int cycles);
    cycles = 0;
    @(negedge clk);
    while (!res_valid && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic applyStimulus(input int id, input logic [31:0] d, input logic [5:0] a,
                               input logic [3:0] m, input int ready_delay,
                               input logic [31:0] exp_d, input logic exp_e,
                               input int exp_lat, input string tag);
    int cycles;
    @(negedge clk);
    if (id == 0) begin
      req0_valid = 1'b1; req0_data = d; req0_amount = a; req0_mode = m;
    end else begin
      req1_valid = 1'b1; req1_data = d; req1_amount = a; req1_mode = m;
    end
    #1;
    checkOutput({tag, "_ready"}, 32'((id == 0) ? req0_ready : req1_ready), 32'd1);
    @(posedge clk);
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = ~d; req1_data = ~d;
    req0_amount = 6'($urandom); req1_amount = 6'($urandom);
    req0_mode = 4'($urandom); req1_mode = 4'($urandom);
    waitResult(cycles);
    checkOutput({tag, "_latency"}, 32'(cycles), 32'(exp_lat));
    checkOutput({tag, "_data"}, res_data, exp_d);
    checkOutput({tag, "_id"}, 32'(res_id), 32'(id));
    checkOutput({tag, "_error"}, 32'(res_error), 32'(exp_e));
    repeat (ready_delay) @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
  endtask

  initial begin
    int          cycles;
    logic [31:0] held;
    logic        seen;
    logic        merr;
    int          mlat;
    logic [31:0] mdata;

    tbl[0]  = '{0, 32'h80000000, 6'd4,  4'b0001, 32'h08000000, 1'b0, 4};
    tbl[1]  = '{0, 32'hF0000000, 6'd8,  4'b0010, 32'hFFF00000, 1'b0, 8};
    tbl[2]  = '{0, 32'hF0000000, 6'd40, 4'b0001, 32'h00000000, 1'b0, 32};
    tbl[3]  = '{1, 32'h00000001, 6'd33, 4'b1000, 32'h80000000, 1'b0, 1};
    tbl[4]  = '{1, 32'h12345678, 6'd0,  4'b0001, 32'h12345678, 1'b0, 0};
    tbl[5]  = '{1, 32'h1234ABCD, 6'd5,  4'b0100, 32'h1234ABCD, 1'b1, 0};
    tbl[6]  = '{0, 32'h80000001, 6'd63, 4'b0010, 32'hFFFFFFFF, 1'b0, 32};
    tbl[7]  = '{1, 32'h0000000F, 6'd4,  4'b1000, 32'hF0000000, 1'b0, 4};
    tbl[8]  = '{0, 32'hDEADBEEF, 6'd32, 4'b1000, 32'hDEADBEEF, 1'b0, 0};
    tbl[9]  = '{1, 32'hFFFFFFFF, 6'd31, 4'b0001, 32'h00000001, 1'b0, 31};
    tbl[10] = '{0, 32'h40000000, 6'd63, 4'b0010, 32'h00000000, 1'b0, 32};
    tbl[11] = '{0, 32'h0000ABCD, 6'd0,  4'b0000, 32'h0000ABCD, 1'b1, 0};

    rst = 1'b1; res_ready = 1'b0;
    req0_valid = 1'b0; req0_data = '0; req0_amount = '0; req0_mode = 4'b0001;
    req1_valid = 1'b0; req1_data = '0; req1_amount = '0; req1_mode = 4'b0001;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_valid", 32'(res_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_data", res_data, 32'h0);
    checkOutput("rst_id_err", {30'd0, res_id, res_error}, 32'd0);
    rst = 1'b0;

    // Arbitration: both valid from reset, held valid; expect grants 0,1,0,1.
    @(negedge clk);
    req0_valid = 1'b1; req0_data = 32'hA0000000; req0_amount = 6'd2; req0_mode = 4'b0001;
    req1_valid = 1'b1; req1_data = 32'h0000F000; req1_amount = 6'd3; req1_mode = 4'b0001;
    res_ready = 1'b1;
    #1;
    checkOutput("arb_ready0", 32'(req0_ready), 32'd1);
    checkOutput("arb_ready1", 32'(req1_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cycles = 0;
      @(negedge clk);
      while (!res_valid && cycles < 100) begin
        @(negedge clk);
        cycles++;
      end
      checkOutput("alt_id", 32'(res_id), 32'(i % 2));
      checkOutput("alt_data", res_data, (i % 2) ? 32'h00001E00 : 32'h28000000);
      @(posedge clk);
    end
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;

    for (int i = 0; i < 12; i++)
      applyStimulus(tbl[i].id, tbl[i].data, tbl[i].amount, tbl[i].mode, i % 3,
                    tbl[i].exp_data, tbl[i].exp_err, tbl[i].exp_lat, $sformatf("tbl%0d", i));

    // Backpressure with an illegal mode while req0 waits.
    @(negedge clk);
    req1_valid = 1'b1; req1_data = 32'h1234ABCD; req1_amount = 6'd7; req1_mode = 4'b0100;
    @(posedge clk);
    #1;
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_data = 32'h1; req0_amount = 6'd1; req0_mode = 4'b0001;
    waitResult(cycles);
    checkOutput("bp_latency", 32'(cycles), 32'd0);
    held = res_data;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("bp_valid", 32'(res_valid), 32'd1);
      checkOutput("bp_data", res_data, 32'h1234ABCD);
      checkOutput("bp_stable", res_data, held);
      checkOutput("bp_id_err", {30'd0, res_id, res_error}, 32'd3);
      checkOutput("bp_readies", {30'd0, req0_ready, req1_ready}, 32'd0);
      checkOutput("bp_busy", 32'(busy), 32'd1);
    end
    req0_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;

    // Serve req0 so the pointer favours req1, then abort a 10-step shift with reset.
    applyStimulus(0, 32'h00000100, 6'd1, 4'b0001, 0, 32'h00000080, 1'b0, 1, "pre_rst");
    @(negedge clk);
    req0_valid = 1'b1; req0_data = 32'hFFFF0000; req0_amount = 6'd10; req0_mode = 4'b0001;
    @(posedge clk);
    #1 req0_valid = 1'b0;
    @(negedge clk);
    checkOutput("mid_busy", 32'(busy), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_valid", 32'(res_valid), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checkOutput("abort_ptr", {30'd0, req0_ready, req1_ready}, 32'd2);
    req0_valid = 1'b0; req1_valid = 1'b0;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      seen = seen | res_valid | busy;
    end
    checkOutput("abort_no_stale", 32'(seen), 32'd0);

    for (int i = 0; i < 40; i++) begin
      int          sel;
      int          rid;
      logic [31:0] rd;
      logic [5:0]  ra;
      logic [3:0]  rm;
      sel = $urandom_range(0, 7);
      rid = $urandom_range(0, 1);
      rd = $urandom;
      ra = 6'($urandom_range(0, 63));
      rm = (sel < 2) ? 4'b0001 : (sel < 4) ? 4'b0010 : (sel < 6) ? 4'b1000 : 4'($urandom);
      mdata = modelResult(rd, ra, rm, merr, mlat);
      applyStimulus(rid, rd, ra, rm, $urandom_range(0, 2), mdata, merr, mlat,
                    $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/shift_arbiter_seq.md
Name: shift_arbiter_seq

Overview:
Iterative right-shift engine with a two-requester front end. It arbitrates round-robin between two requesters and performs logical, arithmetic or rotate right shifts one bit position per clock. Each result is returned through a valid/ready output handshake tagged with the requester ID. It replaces a wide combinational shifter wherever area matters more than latency, and lets two datapath clients share one engine.

Parameters:
WIDTH, 32, data width in bits; must be a power of two (rotate reduction relies on it)
SHIFT, 5, shift-amount port is SHIFT+1 bits wide, so the range is 0..2^(SHIFT+1)-1

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle when high with valid
req0_data  input  WIDTH  requester 0 operand
req0_amount  input  SHIFT+1  requester 0 shift amount
req0_mode  input  4  0001=logical, 0010=arithmetic, 1000=rotate right
req1_valid, req1_ready, req1_data, req1_amount, req1_mode  same as requester 0, for requester 1
res_valid  output  1  result available
res_ready  input  1  consumer takes result
res_data  output  WIDTH  shifted result
res_id  output  1  requester that issued the result
res_error  output  1  mode was not one of the three legal codes
busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset: one clock, active-high, synchronous. State=IDLE, res_valid=0, res_data=0, res_id=0, res_error=0, busy=0, priority pointer favours req0. Reset mid-operation aborts it; no result is produced and nothing is replayed.
- States: IDLE, SHIFT, DONE.
- IDLE, grant:
  - Grant goes to the single valid requester. If both are valid, grant goes to the requester favoured by the pointer.
  - reqN_ready is combinational: high only in IDLE for the granted requester. Both ready signals are low in SHIFT and DONE.
  - Transfer occurs on valid&&ready. At that edge the block captures data, mode and id, and loads the effective count.
- Effective count:
  - logical or arithmetic: min(amount, WIDTH).
  - rotate: amount mod WIDTH (low log2(WIDTH) bits).
- Next state after the accepting edge:
  - illegal mode (anything other than 0001, 0010, 1000): DONE with res_data=operand unchanged and res_error=1.
  - legal mode, count 0: DONE with res_data=operand and res_error=0.
  - otherwise: SHIFT.
- SHIFT: each edge performs one step and decrements count. On the edge where count==1 the block moves to DONE.
  - logical: {0, d[W-1:1]}
  - arithmetic: {d[W-1], d[W-1:1]}
  - rotate: {d[0], d[W-1:1]}
- Latency: res_valid rises after count further edges following the accepting edge. Count 0 or illegal mode: res_valid is high immediately after the accepting edge. Worst case is WIDTH edges.
- DONE:
  - res_valid=1, with res_data, res_id and res_error held stable until res_ready.
  - On res_valid&&res_ready: go to IDLE, clear res_valid, and point the pointer at the requester not just served.
  - A new grant is possible at the earliest in the cycle after the handshake (IDLE cycle).
- Requester dropping valid before ready: legal, nothing is captured. Operand and amount are sampled only at the transfer edge; later input changes are ignored.
- res_ready high while res_valid is low has no effect.

Test Plan:
- Logical, WIDTH=32: req0 data=0x80000000, amount=4, mode=0001 -> res_data=0x08000000, res_id=0, res_error=0; res_valid high 4 edges after the accepting edge.
- Arithmetic and logical clamp:
  - data=0xF0000000, amount=8, mode=0010 -> 0xFFF00000.
  - data=0xF0000000, amount=40, mode=0001 -> 0x00000000 after exactly 32 SHIFT edges.
- Rotate reduction and zero amount:
  - data=0x00000001, amount=33, mode=1000 -> 0x80000000 after 1 step.
  - amount=0, mode=0001 -> res_data=operand, res_valid immediately after accepting edge.
- Arbitration: from reset, both valid together (req0 amount=2, req1 amount=3) -> req0 served first (res_id=0), then req1 (res_id=1); with both held continuously valid, grants alternate 0,1,0,1.
- Backpressure and illegal mode:
  - req1 mode=0100, data=0x1234ABCD -> res_error=1, res_data=0x1234ABCD.
  - res_ready held low 3 cycles -> outputs stable, both ready signals low, busy=1 throughout.
- Reset mid-SHIFT: assert rst 2 cycles into a 10-bit shift -> next cycle state IDLE, res_valid=0, busy=0, pointer favours req0, no stale result afterwards.
